fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that lets NUM_REQ producers share the single write port of fifo_dut.
- Drives the FIFO's active-low write enable and data-in.
- Honours the FIFO full flag.
- Returns a one-hot per-requester acknowledge for every word the FIFO accepts.
- A granted requester holds the port for up to MAX_BURST words, then ownership rotates.

Parameters:
NUM_REQ, 4, number of producers (2..8).
DW, 8, data width; matches the fifo_dut din/dout width.
MAX_BURST, 4, maximum words written per grant (>=1).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
req  input  NUM_REQ  per-producer request; level; held while the producer has a word presented.
req_data  input  NUM_REQ*DW  flattened producer data; producer i occupies bits [i*DW +: DW].
ack  output  NUM_REQ  one-hot; high in the cycle the owner's word is written into the FIFO.
fifo_wr_n  output  1  to fifo_dut wr_n; active-low write strobe.
fifo_din  output  DW  to fifo_dut din.
fifo_full  input  1  from fifo_dut full.
grant_valid  output  1  high while in GRANT.
grant_id  output  $clog2(NUM_REQ)  current owner index; 0 when not granted.

Behaviour:
- Reset (rst_n=0 at a clk edge): the next state is IDLE; rr_ptr=0, owner=0, burst_cnt=0.
  - While in reset and after it: fifo_wr_n=1, ack=0, fifo_din=0, grant_valid=0, grant_id=0.
  - Reset overrides every other event, including one in the middle of a burst.
  - No write may occur in any cycle where rst_n=0 is sampled.
- State register: IDLE or GRANT.
  - owner: $clog2(NUM_REQ) bits.
  - rr_ptr: $clog2(NUM_REQ) bits.
  - burst_cnt: $clog2(MAX_BURST+1) bits.
- IDLE:
  - If req != 0, owner <= the first asserted index searching upward from rr_ptr, wrapping modulo NUM_REQ; burst_cnt <= 0; go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration latency: 1 cycle from req to the first possible write.
- GRANT, outputs:
  - write = req[owner] & ~fifo_full.
  - fifo_wr_n = ~write (combinational from registered state).
  - fifo_din = req_data slice of owner.
  - ack[owner] = write; all other ack bits are 0.
- GRANT, word accounting:
  - On write, burst_cnt <= burst_cnt + 1.
  - fifo_full=1 stalls the grant: no write, no ack, burst_cnt held, ownership held.
- GRANT, release: release occurs when req[owner]=0, or when write occurs with burst_cnt == MAX_BURST-1.
  - On release: rr_ptr <= (owner+1) mod NUM_REQ; next state IDLE.
  - IDLE always costs one bubble cycle between grants.
- Dropping request while full: if req[owner] drops while fifo_full=1, release immediately with no write.
- Requester contract:
  - A producer advances to its next word on the cycle after it sees ack.
  - A producer may deassert req at any time; no word is written in a cycle where req[owner]=0.
- Outside GRANT: fifo_din = 0 and fifo_wr_n = 1.
- Write limit: at most one write per cycle; ack is never multi-hot.
- Loss/duplication: no word is lost or duplicated.
- Fairness: any continuously requesting producer is granted within NUM_REQ grant rounds.
- fifo_dut timing: fifo_dut samples wr_n/din at the same rising edge at which ack is seen high.

Test Plan:
1. Reset: rst_n=0 for 5 cycles with req=4'b1111 → fifo_wr_n=1, ack=0, grant_valid=0 throughout. Release → grant_id=0 and grant_valid=1 one cycle later; first write (ack=4'b0001) in that cycle.
2. Burst limit: only req[1] asserted, 6 words (0x10..0x15), fifo_full=0 → FIFO receives 0x10..0x13 on 4 consecutive cycles, then 1 IDLE bubble, regrant to 1, then 0x14, 0x15. Six ack pulses total. Reading the FIFO back returns 0x10..0x15 in order.
3. Round-robin: all four requesters, 2 words each (requester i sends 0xi0, 0xi1) → grant order 0,1,2,3. FIFO contents 00,01,10,11,20,21,30,31. Each grant is released on req drop, with one bubble between grants.
4. Full stall: req[0] in mid-burst after 2 writes; fifo_full=1 for 3 cycles → fifo_wr_n=1, ack=0, grant_id=0 held. Full drops → 2 more writes, then release (4 writes total in the burst).
5. Reset mid-burst: rst_n=0 for 1 cycle during owner=2 after 1 write → the next cycle is IDLE with fifo_wr_n=1, ack=0. After rst_n=1 with req=4'b1100 → owner=2 (rr_ptr reset to 0, search 0→2).
6. Drop while full: owner=2 and fifo_full=1; req[2] deasserts → no write; release on that edge. With req=4'b1001 pending, the next owner is 3, not 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of fifo_dut among NUM_REQ producers.
// A grant lasts up to MAX_BURST accepted words; every grant is followed by one IDLE cycle.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       fifo_wr_n,
    output logic [DW-1:0]              fifo_din,
    input  logic                       fifo_full,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_nxt;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_cnt_nxt;

    logic [IW-1:0] pick;
    logic          pick_found;
    logic          owner_req;
    logic [DW-1:0] owner_data;
    logic          write;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IW'(s);
    endfunction

    // First asserted request at or above rr_ptr, wrapping around.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[wrap_add(rr_ptr, i)]) begin
                pick       = wrap_add(rr_ptr, i);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                owner_req  = req[i];
                owner_data = req_data[i*DW +: DW];
            end
        end
    end

    // Reset is gated in so that no write can slip out while rst_n is low.
    assign write = rst_n && (state == GRANT) && owner_req && !fifo_full;

    always_comb begin
        ack         = '0;
        fifo_wr_n   = 1'b1;
        fifo_din    = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (rst_n && (state == GRANT)) begin
            grant_valid = 1'b1;
            grant_id    = owner;
            fifo_din    = owner_data;
            fifo_wr_n   = ~write;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ack[i] = write && (owner == IW'(i));
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt     = pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_nxt     = IDLE;
                    rr_ptr_nxt    = wrap_add(owner, 1);
                    burst_cnt_nxt = '0;
                end else if (write) begin
                    burst_cnt_nxt = burst_cnt + CW'(1);
                    if (burst_cnt == CW'(MAX_BURST - 1)) begin
                        state_nxt     = IDLE;
                        rr_ptr_nxt    = wrap_add(owner, 1);
                        burst_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues and a FIFO capture model,
// checked with immediate assertions against hand-computed expectations.
module tb_fifo_wr_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_wr_n;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int vectors     = 0;
    int miscompares = 0;
    int proto_err   = 0;
    int ack_cnt     = 0;

    logic [7:0] words [4][8];
    int         head [4];
    int         cnt [4];
    logic [3:0] en;
    logic [7:0] fq [$];
    logic [1:0] wq [$];
    logic [1:0] t2_pat [9];

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DW       (DW),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_wr_n  (fifo_wr_n),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < cnt[i]) begin
                req[i]            = en[i];
                req_data[i*8 +: 8] = words[i][head[i]];
            end else begin
                req[i]            = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    function automatic int pending();
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && head[i] < cnt[i]) p++;
        end
        return p;
    endfunction

    function automatic logic [7:0] fq_at(input int k);
        if (k < fq.size()) return fq[k];
        return 8'hxx;
    endfunction

    function automatic logic [1:0] wq_at(input int k);
        if (k < wq.size()) return wq[k];
        return 2'bxx;
    endfunction

    task automatic settle();
        drive_req();
        #1;
    endtask

    // Observe the current cycle (FIFO capture, producer advance), then move to the next one.
    task automatic tick();
        logic [3:0] exp_ack;
        exp_ack = fifo_wr_n ? 4'b0000 : (4'b0001 << grant_id);
        if (ack !== exp_ack) proto_err++;
        if (!fifo_wr_n && fifo_full) proto_err++;
        if (!fifo_wr_n) begin
            fq.push_back(fifo_din);
            wq.push_back(grant_id);
        end
        ack_cnt += $countones(ack);
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) head[i]++;
        end
        @(negedge clk);
        settle();
    endtask

    task automatic load(input int i, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) words[i][k] = 8'(base + 8'(k));
        head[i] = 0;
        cnt[i]  = n;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        en = 4'b0000;
        fq.delete();
        wq.delete();
        ack_cnt = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(pending()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        settle();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    initial begin
        t2_pat    = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        req       = '0;
        req_data  = '0;
        clear_all();
        @(negedge clk);
        settle();

        // 1: reset with all requesting, then first grant and write
        load(0, 8'hA0, 1);
        load(1, 8'hA1, 1);
        load(2, 8'hA2, 1);
        load(3, 8'hA3, 1);
        en = 4'b1111;
        settle();
        for (int c = 0; c < 5; c++) begin
            chk("t1_reset", 32'({grant_valid, fifo_wr_n, ack}), 32'({1'b0, 1'b1, 4'b0000}));
            tick();
        end
        rst_n = 1'b1;
        settle();
        chk("t1_idle", 32'(grant_valid), 32'd0);
        tick();
        chk("t1_first", 32'({grant_valid, grant_id, fifo_wr_n, ack, fifo_din}),
            32'({1'b1, 2'd0, 1'b0, 4'b0001, 8'hA0}));
        drain("t1_drain");
        chk("t1_count", 32'(fq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("t1_order", 32'({wq_at(k), fq_at(k)}), 32'({2'(k), 8'(8'hA0 + k)}));

        // 2: burst limit with a single requester
        clear_all();
        load(1, 8'h10, 6);
        en = 4'b0010;
        settle();
        chk("t2_idle", 32'(grant_valid), 32'd0);
        tick();
        for (int c = 0; c < 9; c++) begin
            chk("t2_cycle", 32'({grant_valid, fifo_wr_n}), 32'(t2_pat[c]));
            tick();
        end
        chk("t2_acks", 32'(ack_cnt), 32'd6);
        chk("t2_count", 32'(fq.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("t2_word", 32'({wq_at(k), fq_at(k)}), 32'({2'd1, 8'(8'h10 + k)}));

        // 3: round robin across all four, two words each
        clear_all();
        apply_reset();
        for (int i = 0; i < 4; i++) load(i, 8'(i * 16), 2);
        en = 4'b1111;
        settle();
        drain("t3_drain");
        chk("t3_count", 32'(fq.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("t3_word", 32'({wq_at(k), fq_at(k)}), 32'({2'(k / 2), 8'((k / 2) * 16 + k % 2)}));

        // 4: full stall in the middle of a burst
        clear_all();
        load(0, 8'h40, 4);
        en = 4'b0001;
        settle();
        tick();
        chk("t4_w0", 32'({fifo_wr_n, fifo_din}), 32'({1'b0, 8'h40}));
        tick();
        chk("t4_w1", 32'({fifo_wr_n, fifo_din}), 32'({1'b0, 8'h41}));
        tick();
        fifo_full = 1'b1;
        settle();
        for (int c = 0; c < 3; c++) begin
            chk("t4_stall", 32'({grant_valid, grant_id, fifo_wr_n, ack}),
                32'({1'b1, 2'd0, 1'b1, 4'b0000}));
            tick();
        end
        fifo_full = 1'b0;
        settle();
        chk("t4_w2", 32'({fifo_wr_n, fifo_din}), 32'({1'b0, 8'h42}));
        tick();
        chk("t4_w3", 32'({fifo_wr_n, fifo_din}), 32'({1'b0, 8'h43}));
        tick();
        chk("t4_release", 32'(grant_valid), 32'd0);
        drain("t4_drain");
        chk("t4_count", 32'(fq.size()), 32'd4);

        // 5: reset in the middle of a burst
        clear_all();
        load(2, 8'h50, 3);
        en = 4'b0100;
        settle();
        tick();
        chk("t5_w0", 32'({grant_id, fifo_wr_n, fifo_din}), 32'({2'd2, 1'b0, 8'h50}));
        tick();
        rst_n = 1'b0;
        settle();
        chk("t5_rst", 32'({grant_valid, grant_id, fifo_wr_n, ack, fifo_din}),
            32'({1'b0, 2'd0, 1'b1, 4'b0000, 8'h00}));
        tick();
        rst_n = 1'b1;
        load(3, 8'h53, 1);
        en = 4'b1100;
        settle();
        chk("t5_idle", 32'({grant_valid, fifo_wr_n, ack}), 32'({1'b0, 1'b1, 4'b0000}));
        tick();
        chk("t5_regrant", 32'({grant_id, ack, fifo_din}), 32'({2'd2, 4'b0100, 8'h51}));
        drain("t5_drain");
        chk("t5_count", 32'(fq.size()), 32'd4);
        chk("t5_word0", 32'({wq_at(0), fq_at(0)}), 32'({2'd2, 8'h50}));
        chk("t5_word1", 32'({wq_at(1), fq_at(1)}), 32'({2'd2, 8'h51}));
        chk("t5_word2", 32'({wq_at(2), fq_at(2)}), 32'({2'd2, 8'h52}));
        chk("t5_word3", 32'({wq_at(3), fq_at(3)}), 32'({2'd3, 8'h53}));

        // 6: owner drops its request while the FIFO is full
        clear_all();
        load(2, 8'h60, 2);
        en = 4'b0100;
        settle();
        tick();
        chk("t6_w0", 32'({grant_id, fifo_wr_n, fifo_din}), 32'({2'd2, 1'b0, 8'h60}));
        tick();
        fifo_full = 1'b1;
        settle();
        chk("t6_stall", 32'({grant_valid, grant_id, fifo_wr_n, ack}), 32'({1'b1, 2'd2, 1'b1, 4'b0000}));
        load(0, 8'h70, 1);
        load(3, 8'h73, 1);
        en = 4'b1001;
        settle();
        chk("t6_drop", 32'({grant_valid, grant_id, fifo_wr_n, ack}), 32'({1'b1, 2'd2, 1'b1, 4'b0000}));
        tick();
        chk("t6_idle", 32'(grant_valid), 32'd0);
        fifo_full = 1'b0;
        settle();
        tick();
        chk("t6_next", 32'({grant_id, ack, fifo_din}), 32'({2'd3, 4'b1000, 8'h73}));
        drain("t6_drain");
        chk("t6_count", 32'(fq.size()), 32'd3);
        chk("t6_word0", 32'({wq_at(0), fq_at(0)}), 32'({2'd2, 8'h60}));
        chk("t6_word1", 32'({wq_at(1), fq_at(1)}), 32'({2'd3, 8'h73}));
        chk("t6_word2", 32'({wq_at(2), fq_at(2)}), 32'({2'd0, 8'h70}));

        chk("protocol", 32'(proto_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
